// File: rtl/bp_be_ctxt_switch_ctrl.sv
// Context-switch initiator: validates a target thread, drains the pipe, strobes CTXT, reports done.
// Optional round-robin quantum preemption compiled in with BP_BE_CTXT_PREEMPT_TIMER_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bp_be_ctxt_switch_ctrl #(
  parameter int unsigned num_threads_p     = 1,
  parameter int unsigned thread_id_width_p = `BSG_SAFE_CLOG2(num_threads_p),
  parameter int unsigned quantum_p         = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_v_i,
  input  logic [thread_id_width_p-1:0] req_thread_i,
  output logic                         req_ready_o,
  input  logic [thread_id_width_p-1:0] cur_thread_i,
  input  logic                         pipe_empty_i,
  output logic                         stall_o,
  output logic                         csr_write_ctxt_v_o,
  output logic [thread_id_width_p-1:0] csr_write_ctxt_data_o,
  output logic                         flush_o,
  output logic                         done_v_o,
  output logic                         done_err_o
);

  if (quantum_p < 2) begin : g_bad_quantum
    $error("quantum_p must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                         r_state;
  logic [thread_id_width_p-1:0]   r_target;
  logic                           r_internal;
  logic                           r_stall;
  logic                           r_wr_v;
  logic [thread_id_width_p-1:0]   r_wr_data;
  logic                           r_flush;
  logic                           r_done_v;
  logic                           r_done_err;

  logic                           w_idle;
  logic                           w_accept_ext;
  logic                           w_req_int;
  logic                           w_accept;
  logic [thread_id_width_p-1:0]   w_req_target;
  logic                           w_tgt_err;
  logic                           w_tgt_same;

  assign w_idle       = (r_state == IDLE) & ~reset_i;
  assign req_ready_o  = w_idle;
  assign w_accept_ext = req_v_i & w_idle;

`ifdef BP_BE_CTXT_PREEMPT_TIMER_EN
  localparam int unsigned cnt_width_lp = $clog2(quantum_p);

  logic [cnt_width_lp-1:0]      r_cnt;
  logic                         w_expire;
  logic [31:0]                  w_inc;
  logic [thread_id_width_p-1:0] w_int_target;

  assign w_expire     = (r_cnt == cnt_width_lp'(quantum_p - 1));
  assign w_inc        = 32'(cur_thread_i) + 32'd1;
  assign w_int_target = (w_inc >= num_threads_p) ? '0 : w_inc[thread_id_width_p-1:0];
  // External requests win an expiry cycle; the internal one is simply dropped.
  assign w_req_int    = w_idle & w_expire & ~req_v_i;
  assign w_req_target = w_accept_ext ? req_thread_i : w_int_target;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (w_accept_ext | w_req_int) begin
      r_cnt <= '0;
    end else if (w_idle) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_req_int    = 1'b0;
  assign w_req_target = req_thread_i;
`endif

  assign w_accept   = w_accept_ext | w_req_int;
  assign w_tgt_err  = (32'(w_req_target) >= num_threads_p);
  assign w_tgt_same = (w_req_target == cur_thread_i);

  // Outputs are registered alongside the state so each is a pure state decode.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_internal <= 1'b0;
      r_stall    <= 1'b0;
      r_wr_v     <= 1'b0;
      r_wr_data  <= '0;
      r_flush    <= 1'b0;
      r_done_v   <= 1'b0;
      r_done_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_target   <= w_req_target;
            r_internal <= w_req_int;
            r_stall    <= 1'b1;
            if (w_tgt_err) begin
              r_state    <= RESP;
              r_done_v   <= ~w_req_int;
              r_done_err <= 1'b1;
            end else if (w_tgt_same) begin
              r_state    <= RESP;
              r_done_v   <= ~w_req_int;
              r_done_err <= 1'b0;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty_i) begin
            r_state   <= SWITCH;
            r_wr_v    <= 1'b1;
            r_wr_data <= r_target;
            r_flush   <= 1'b1;
          end
        end
        SWITCH: begin
          r_state    <= RESP;
          r_wr_v     <= 1'b0;
          r_wr_data  <= '0;
          r_flush    <= 1'b0;
          r_done_v   <= ~r_internal;
          r_done_err <= 1'b0;
        end
        RESP: begin
          r_state    <= IDLE;
          r_stall    <= 1'b0;
          r_done_v   <= 1'b0;
          r_done_err <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stall_o               = r_stall;
  assign csr_write_ctxt_v_o    = r_wr_v;
  assign csr_write_ctxt_data_o = r_wr_data;
  assign flush_o               = r_flush;
  assign done_v_o              = r_done_v;
  assign done_err_o            = r_done_err;

endmodule

// File: tb/tb_bp_be_ctxt_switch_ctrl.sv
// Directed bench for bp_be_ctxt_switch_ctrl; timer section is active when BP_BE_CTXT_PREEMPT_TIMER_EN is defined.
`timescale 1ns/1ps

module tb_bp_be_ctxt_switch_ctrl;

  logic       clk;
  logic       reset;
  logic       req_v;
  logic [2:0] req_thread;
  logic       ready;
  logic [2:0] cur;
  logic       pe;
  logic       stall;
  logic       wv;
  logic [2:0] wd;
  logic       flush;
  logic       dv;
  logic       de;

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bp_be_ctxt_switch_ctrl #(
    .num_threads_p     (4),
    .thread_id_width_p (3)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (reset),
    .req_v_i               (req_v),
    .req_thread_i          (req_thread),
    .req_ready_o           (ready),
    .cur_thread_i          (cur),
    .pipe_empty_i          (pe),
    .stall_o               (stall),
    .csr_write_ctxt_v_o    (wv),
    .csr_write_ctxt_data_o (wd),
    .flush_o               (flush),
    .done_v_o              (dv),
    .done_err_o            (de)
  );

`ifdef BP_BE_CTXT_PREEMPT_TIMER_EN
  logic       t_reset;
  logic       t_req_v;
  logic [1:0] t_req_thread;
  logic       t_ready;
  logic [1:0] t_cur;
  logic       t_pe;
  logic       t_stall;
  logic       t_wv;
  logic [1:0] t_wd;
  logic       t_flush;
  logic       t_dv;
  logic       t_de;

  bp_be_ctxt_switch_ctrl #(
    .num_threads_p     (3),
    .thread_id_width_p (2),
    .quantum_p         (8)
  ) dut_tmr (
    .clk_i                 (clk),
    .reset_i               (t_reset),
    .req_v_i               (t_req_v),
    .req_thread_i          (t_req_thread),
    .req_ready_o           (t_ready),
    .cur_thread_i          (t_cur),
    .pipe_empty_i          (t_pe),
    .stall_o               (t_stall),
    .csr_write_ctxt_v_o    (t_wv),
    .csr_write_ctxt_data_o (t_wd),
    .flush_o               (t_flush),
    .done_v_o              (t_dv),
    .done_err_o            (t_de)
  );

  task automatic exp_t(input string tag, input bit st, input bit w, input int d,
                       input bit fl, input bit dvx, input bit rdy);
    chk({tag, ".stall"}, 32'(t_stall), 32'(st));
    chk({tag, ".wr_v"},  32'(t_wv),    32'(w));
    chk({tag, ".data"},  32'(t_wd),    32'(d));
    chk({tag, ".flush"}, 32'(t_flush), 32'(fl));
    chk({tag, ".done"},  32'(t_dv),    32'(dvx));
    chk({tag, ".ready"}, 32'(t_ready), 32'(rdy));
  endtask
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_o(input string tag, input bit st, input bit w, input int d,
                       input bit fl, input bit dvx, input bit dex, input bit rdy);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".wr_v"},  32'(wv),    32'(w));
    chk({tag, ".data"},  32'(wd),    32'(d));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".done"},  32'(dv),    32'(dvx));
    chk({tag, ".err"},   32'(de),    32'(dex));
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_v = 1'b0; req_thread = '0; cur = '0; pe = 1'b0;
`ifdef BP_BE_CTXT_PREEMPT_TIMER_EN
    t_reset = 1'b1; t_req_v = 1'b0; t_req_thread = '0; t_cur = 2'd2; t_pe = 1'b1;
`endif
    tick(); tick();
    exp_o("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    exp_o("post_reset", 0, 0, 0, 0, 0, 0, 1);

    // Switch to 2, pipe drains at T+3
    req_v = 1'b1; req_thread = 3'd2; cur = 3'd0; pe = 1'b0;
    tick(); req_v = 1'b0;
    exp_o("sw2.t1", 1, 0, 0, 0, 0, 0, 0);
    tick();
    exp_o("sw2.t2", 1, 0, 0, 0, 0, 0, 0);
    tick();
    exp_o("sw2.t3", 1, 0, 0, 0, 0, 0, 0);
    pe = 1'b1;
    tick(); pe = 1'b0;
    exp_o("sw2.t4", 1, 1, 2, 1, 0, 0, 0);
    tick();
    exp_o("sw2.t5", 1, 0, 0, 0, 1, 0, 0);
    tick();
    exp_o("sw2.t6", 0, 0, 0, 0, 0, 0, 1);

    // Out-of-range targets 5 and 4
    req_v = 1'b1; req_thread = 3'd5;
    tick(); req_v = 1'b0;
    exp_o("err5.t1", 1, 0, 0, 0, 1, 1, 0);
    tick();
    exp_o("err5.t2", 0, 0, 0, 0, 0, 0, 1);
    req_v = 1'b1; req_thread = 3'd4;
    tick(); req_v = 1'b0;
    exp_o("err4.t1", 1, 0, 0, 0, 1, 1, 0);
    tick();
    exp_o("err4.t2", 0, 0, 0, 0, 0, 0, 1);

    // No-op back-to-back: request held, re-accepted after 2 cycles
    cur = 3'd1; req_v = 1'b1; req_thread = 3'd1;
    tick();
    exp_o("noop.a1", 1, 0, 0, 0, 1, 0, 0);
    tick();
    exp_o("noop.a2", 0, 0, 0, 0, 0, 0, 1);
    tick(); req_v = 1'b0;
    exp_o("noop.b1", 1, 0, 0, 0, 1, 0, 0);
    tick();
    exp_o("noop.b2", 0, 0, 0, 0, 0, 0, 1);

    // Minimum-latency switch to 3
    cur = 3'd0; req_v = 1'b1; req_thread = 3'd3; pe = 1'b1;
    tick(); req_v = 1'b0;
    exp_o("sw3.t1", 1, 0, 0, 0, 0, 0, 0);
    tick();
    exp_o("sw3.t2", 1, 1, 3, 1, 0, 0, 0);
    tick();
    exp_o("sw3.t3", 1, 0, 0, 0, 1, 0, 0);
    tick();
    exp_o("sw3.t4", 0, 0, 0, 0, 0, 0, 1);

    // Reset during DRAIN discards the request
    req_v = 1'b1; req_thread = 3'd2; pe = 1'b0;
    tick(); req_v = 1'b0;
    exp_o("rst_drain.t1", 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    exp_o("rst_drain.t2", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0; pe = 1'b1;
    #1;
    exp_o("rst_drain.t2r", 0, 0, 0, 0, 0, 0, 1);
    tick();
    exp_o("rst_drain.t3", 0, 0, 0, 0, 0, 0, 1);
    tick();
    exp_o("rst_drain.t4", 0, 0, 0, 0, 0, 0, 1);
    tick();
    exp_o("rst_drain.t5", 0, 0, 0, 0, 0, 0, 1);

`ifdef BP_BE_CTXT_PREEMPT_TIMER_EN
    // Quantum 8, 3 threads, current 2: internal switch to 0 at counter 7
    t_reset = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      exp_t("tmr.count", 0, 0, 0, 0, 0, 1);
      tick();
    end
    exp_t("tmr.c7", 0, 0, 0, 0, 0, 1);
    tick();
    exp_t("tmr.c8", 1, 0, 0, 0, 0, 0);
    tick();
    exp_t("tmr.c9", 1, 1, 0, 1, 0, 0);
    tick();
    exp_t("tmr.c10", 1, 0, 0, 0, 0, 0);
    tick();
    exp_t("tmr.c11", 0, 0, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 7; i++) tick();
    // Expiry cycle again: external request to 1 takes priority
    t_req_v = 1'b1; t_req_thread = 2'd1;
    tick(); t_req_v = 1'b0;
    exp_t("tmr.ext1", 1, 0, 0, 0, 0, 0);
    tick();
    exp_t("tmr.ext2", 1, 1, 1, 1, 0, 0);
    tick();
    exp_t("tmr.ext3", 1, 0, 0, 0, 1, 0);
    tick();
    exp_t("tmr.ext4", 0, 0, 0, 0, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_ctxt_switch_ctrl.md
# bp_be_ctxt_switch_ctrl

Context-switch initiator for the multithreaded backend. Accepts thread-switch requests from the CSR unit (writes to CTXT, 0x081), validates the target, stalls issue and waits for the pipeline to drain, then drives the single-cycle CTXT write into the thread scheduler and reports completion. An optional quantum timer issues round-robin preemption requests through the same path.

## Interface

Parameters:
- num_threads_p, default 1: number of hardware threads.
- thread_id_width_p, default `BSG_SAFE_CLOG2(num_threads_p)`: thread-ID width.
- quantum_p, default 1024: preemption quantum in cycles (only used with the timer compiled in); must be ≥ 2.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- req_v_i, input, 1: switch request valid.
- req_thread_i, input, thread_id_width_p: requested target thread.
- req_ready_o, output, 1: request accepted when req_v_i & req_ready_o.
- cur_thread_i, input, thread_id_width_p: current thread, from the scheduler's thread_id_o.
- pipe_empty_i, input, 1: no instructions in flight.
- stall_o, output, 1: holds fetch/issue.
- csr_write_ctxt_v_o, output, 1: one-cycle CTXT write strobe to the scheduler.
- csr_write_ctxt_data_o, output, thread_id_width_p: target thread; valid with the strobe, otherwise 0.
- flush_o, output, 1: one-cycle frontend flush, coincident with the strobe.
- done_v_o, output, 1: one-cycle completion pulse for external requests.
- done_err_o, output, 1: qualified by done_v_o; 1 means the target was out of range.

## Operation

- States: IDLE, DRAIN, SWITCH, RESP.
- req_ready_o = (state == IDLE) & ~reset_i.
- IDLE, on accept, registers the target, then:
  - target ≥ num_threads_p → RESP with err = 1. No write.
  - target == cur_thread_i → RESP with err = 0. No-op, no write, no flush.
  - otherwise → DRAIN.
- DRAIN: stall_o = 1. When pipe_empty_i is sampled high, go to SWITCH. There is no timeout.
- SWITCH: stall_o = 1. Assert csr_write_ctxt_v_o = 1, csr_write_ctxt_data_o = target, and flush_o = 1, for exactly one cycle. Then go to RESP.
- RESP: stall_o = 1. Assert done_v_o = 1 for exactly one cycle, with done_err_o as recorded. Then go to IDLE.
  - For an internal (preemption) request, done_v_o stays 0 in RESP.
- stall_o = 0 in IDLE.
- Reset mid-operation: return to IDLE and discard the registered target. No strobe, flush, or done is emitted afterward.

## Timing

- Reset values: stall_o = 0, csr_write_ctxt_v_o = 0, csr_write_ctxt_data_o = 0, flush_o = 0, done_v_o = 0, done_err_o = 0, req_ready_o = 0 while reset_i is high.
- All outputs except req_ready_o are registered-state decodes, with no combinational path from req_* inputs.
- Accept at cycle T, with pipe_empty_i = 1 at T+1:
  - T+1: DRAIN.
  - T+2: SWITCH (strobe and flush).
  - T+3: RESP (done).
  - T+4: IDLE, req_ready_o = 1.
- Each additional cycle of pipe_empty_i = 0 in DRAIN adds one cycle of latency.
- No-op or error request accepted at T: done_v_o at T+1, IDLE at T+2.
- Back-to-back: the minimum accept-to-accept spacing is 2 cycles (no-op) or 4 cycles (full switch).

## Configuration

- Macro: BP_BE_CTXT_PREEMPT_TIMER_EN.
- Defined:
  - A cycle counter increments in IDLE and resets to 0 on any accept.
  - When the counter equals quantum_p−1 and req_v_i = 0, an internal request is accepted with target = (cur_thread_i+1), wrapping to 0 when it reaches num_threads_p.
  - An external req_v_i in the same cycle has priority; the counter then resets.
  - Internal requests follow the same FSM but produce no done_v_o.
  - With num_threads_p = 1, every internal request is a no-op.
- Undefined: no counter and no internal requests; only external requests cause switches.

## Test plan

- Reset, then idle with num_threads_p = 4, cur_thread_i = 0: all outputs 0, req_ready_o = 1 from the first post-reset cycle.
- Request thread 2 accepted at T, pipe_empty_i = 0 until T+3: strobe, flush, and data = 2 at T+4; done_v_o = 1 and done_err_o = 0 at T+5; stall_o high T+1..T+5.
- Request thread 5 with num_threads_p = 4: done_v_o = 1 and done_err_o = 1 at T+1; no strobe ever.
- Request thread 1 with cur_thread_i = 1: done_v_o = 1 and done_err_o = 0 at T+1; no strobe or flush.
- reset_i asserted during DRAIN: the FSM is in IDLE next cycle, and no strobe or done_v_o follows.
- Timer build, quantum_p = 8, num_threads_p = 3, cur_thread_i = 2, no external requests:
  - Internal switch to thread 0.
  - Strobe with data = 0 and no done_v_o.
  - An external request arriving in the quantum-expiry cycle wins instead.
